// File: rtl/vertical_state_machine_pkg.sv
// Shared VGA 640x480@60 timing definitions: segment lengths for both axes and
// the 2-bit segment state encoding used by the horizontal and vertical stages.
package vertical_state_machine_pkg;

    localparam int unsigned H_ACTIVE_PIXELS = 640;
    localparam int unsigned H_FRONT_PIXELS  = 16;
    localparam int unsigned H_SYNC_PIXELS   = 96;
    localparam int unsigned H_BACK_PIXELS   = 48;

    localparam int unsigned V_ACTIVE_LINES  = 480;
    localparam int unsigned V_FRONT_LINES   = 10;
    localparam int unsigned V_SYNC_LINES    = 2;
    localparam int unsigned V_BACK_LINES    = 33;

    localparam int unsigned LINE_CNT_W  = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        FRONT_PORCH  = 2'd0,
        SYNC_PULSE   = 2'd1,
        BACK_PORCH   = 2'd2,
        ACTIVE_VIDEO = 2'd3
    } seg_state_t;

    // Segments always advance in a fixed ring; no segment is ever skipped.
    function automatic seg_state_t next_segment(input seg_state_t cur);
        seg_state_t nxt;
        case (cur)
            ACTIVE_VIDEO: nxt = FRONT_PORCH;
            FRONT_PORCH:  nxt = SYNC_PULSE;
            SYNC_PULSE:   nxt = BACK_PORCH;
            default:      nxt = ACTIVE_VIDEO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vertical_state_machine.sv
// Vertical timing generator: counts line_end_i pulses through the active,
// front porch, sync and back porch segments of each frame.
module vertical_state_machine
    import vertical_state_machine_pkg::*;
#(
    parameter int unsigned V_ACTIVE = V_ACTIVE_LINES,
    parameter int unsigned V_FRONT  = V_FRONT_LINES,
    parameter int unsigned V_SYNC   = V_SYNC_LINES,
    parameter int unsigned V_BACK   = V_BACK_LINES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   line_end_i,
    output logic                   vertical_active_video_o,
    output logic                   sync_pulse_o,
    output logic                   frame_start_o,
    output logic [LINE_CNT_W-1:0]  line_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o
);

    localparam logic [LINE_CNT_W-1:0] ACTIVE_LAST = LINE_CNT_W'(V_ACTIVE - 1);
    localparam logic [LINE_CNT_W-1:0] FRONT_LAST  = LINE_CNT_W'(V_FRONT - 1);
    localparam logic [LINE_CNT_W-1:0] SYNC_LAST   = LINE_CNT_W'(V_SYNC - 1);
    localparam logic [LINE_CNT_W-1:0] BACK_LAST   = LINE_CNT_W'(V_BACK - 1);

    seg_state_t             state_q, state_d;
    logic [LINE_CNT_W-1:0]  count_q, count_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   seg_last;

    always_comb begin
        seg_last = 1'b0;
        case (state_q)
            ACTIVE_VIDEO: seg_last = (count_q == ACTIVE_LAST);
            FRONT_PORCH:  seg_last = (count_q == FRONT_LAST);
            SYNC_PULSE:   seg_last = (count_q == SYNC_LAST);
            default:      seg_last = (count_q == BACK_LAST);
        endcase
    end

    // The frame-start pulse and frame counter advance on the edge that closes
    // the back porch, so both become visible in the first active cycle.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        frame_start_d = 1'b0;
        if (line_end_i) begin
            if (seg_last) begin
                count_d = '0;
                state_d = next_segment(state_q);
                frame_start_d = (state_q == BACK_PORCH);
            end else begin
                count_d = count_q + LINE_CNT_W'(1);
            end
        end
        frame_count_d = frame_count_q + {{(FRAME_CNT_W-1){1'b0}}, frame_start_d};
    end

    always_comb begin
        vertical_active_video_o = (state_q == ACTIVE_VIDEO);
        sync_pulse_o            = (state_q != SYNC_PULSE);
        line_o                  = (state_q == ACTIVE_VIDEO) ? count_q : '0;
        frame_start_o           = frame_start_q;
        frame_count_o           = frame_count_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ACTIVE_VIDEO;
            count_q       <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_vertical_state_machine.sv
// Self-checking bench: a default 640x480 instance and a tiny-parameter instance
// driven together, each compared against a line-position model of the frame.
module tb_vertical_state_machine;

    localparam int A_ACT = 480, A_FP = 10, A_SY = 2, A_BP = 33;
    localparam int B_ACT = 2,   B_FP = 1,  B_SY = 1, B_BP = 1;
    localparam int A_TOTAL = A_ACT + A_FP + A_SY + A_BP;
    localparam int B_TOTAL = B_ACT + B_FP + B_SY + B_BP;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       line_end = 1'b0;
    logic       a_active, a_sync, a_fs, b_active, b_sync, b_fs;
    logic [9:0] a_line, b_line;
    logic [7:0] a_fc, b_fc;

    int num_compared = 0;
    int num_mismatched = 0;
    int pos_a = 0, fc_a = 0, pos_b = 0, fc_b = 0;
    bit fs_a = 0, fs_b = 0;
    int fs_count_b = 0;

    always #5 clk = ~clk;

    vertical_state_machine #(.V_ACTIVE(A_ACT), .V_FRONT(A_FP), .V_SYNC(A_SY), .V_BACK(A_BP)) dut_a (
        .clk_i(clk), .rst_i(rst), .line_end_i(line_end),
        .vertical_active_video_o(a_active), .sync_pulse_o(a_sync), .frame_start_o(a_fs),
        .line_o(a_line), .frame_count_o(a_fc)
    );

    vertical_state_machine #(.V_ACTIVE(B_ACT), .V_FRONT(B_FP), .V_SYNC(B_SY), .V_BACK(B_BP)) dut_b (
        .clk_i(clk), .rst_i(rst), .line_end_i(line_end),
        .vertical_active_video_o(b_active), .sync_pulse_o(b_sync), .frame_start_o(b_fs),
        .line_o(b_line), .frame_count_o(b_fc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_compared++;
        if (got !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Frame position model: a line index within the frame, wrapping at the frame total.
    function automatic void advance(inout int pos, inout int fc, inout bit fs, input int total, input bit le);
        if (le) begin
            pos = (pos + 1) % total;
            fs  = (pos == 0);
            if (fs) fc = (fc + 1) % 256;
        end else begin
            fs = 0;
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, " a_active"}, 32'(a_active), 32'(pos_a < A_ACT));
        checkOutput({tag, " a_sync"},   32'(a_sync),
                    32'(!(pos_a >= A_ACT + A_FP && pos_a < A_ACT + A_FP + A_SY)));
        checkOutput({tag, " a_line"},   32'(a_line), (pos_a < A_ACT) ? 32'(pos_a) : 32'd0);
        checkOutput({tag, " a_fs"},     32'(a_fs), 32'(fs_a));
        checkOutput({tag, " a_fc"},     32'(a_fc), 32'(fc_a));
        checkOutput({tag, " b_active"}, 32'(b_active), 32'(pos_b < B_ACT));
        checkOutput({tag, " b_sync"},   32'(b_sync),
                    32'(!(pos_b >= B_ACT + B_FP && pos_b < B_ACT + B_FP + B_SY)));
        checkOutput({tag, " b_line"},   32'(b_line), (pos_b < B_ACT) ? 32'(pos_b) : 32'd0);
        checkOutput({tag, " b_fs"},     32'(b_fs), 32'(fs_b));
        checkOutput({tag, " b_fc"},     32'(b_fc), 32'(fc_b));
    endtask

    task automatic applyStimulus(input bit pulse, input string tag);
        @(negedge clk);
        line_end = pulse;
        @(posedge clk);
        #1;
        advance(pos_a, fc_a, fs_a, A_TOTAL, pulse);
        advance(pos_b, fc_b, fs_b, B_TOTAL, pulse);
        if (b_fs) fs_count_b++;
        checkAll(tag);
    endtask

    // Reset is asserted between clock edges so its effect must be purely asynchronous.
    task automatic doReset(input string tag);
        line_end = 1'b0;
        #3;
        rst = 1'b1;
        pos_a = 0; fc_a = 0; fs_a = 0;
        pos_b = 0; fc_b = 0; fs_b = 0;
        #1;
        checkAll({tag, " async"});
        repeat (2) @(posedge clk);
        #1;
        checkAll({tag, " held"});
        @(negedge clk);
        #2;
        rst = 1'b0;
        fs_count_b = 0;
    endtask

    task automatic advanceTo(input int target, input string tag);
        for (int i = 0; i < A_TOTAL && pos_a != target; i++) applyStimulus(1'b1, tag);
        checkOutput({tag, " reached"}, 32'(pos_a), 32'(target));
    endtask

    initial begin
        int targets[4];
        targets = '{13, 482, 491, 500};

        doReset("reset");

        for (int i = 0; i < A_TOTAL; i++) applyStimulus(1'b1, "full_frame");
        checkOutput("frame_start_after_525", 32'(a_fs), 32'd1);
        checkOutput("frame_count_after_525", 32'(a_fc), 32'd1);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, "to_line10");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, "stuck_pulse");
        checkOutput("stuck_pulse_line", 32'(a_line), 32'd13);

        foreach (targets[t]) begin
            advanceTo(targets[t], "to_idle_point");
            for (int i = 0; i < 1000; i++) applyStimulus(1'b0, "idle_hold");
        end

        for (int i = 0; i < 3000; i++) applyStimulus(1'($urandom_range(0, 1)), "random");

        advanceTo(A_ACT + A_FP, "to_sync");
        checkOutput("sync_low_before_reset", 32'(a_sync), 32'd0);
        doReset("mid_sync_reset");
        applyStimulus(1'b0, "restart_idle");
        checkOutput("restart_line0", 32'(a_line), 32'd0);
        applyStimulus(1'b1, "restart_pulse");
        checkOutput("restart_line1", 32'(a_line), 32'd1);

        doReset("small_reset");
        for (int i = 0; i < 256 * B_TOTAL - 1; i++) applyStimulus(1'b1, "small_frames");
        checkOutput("small_fc_before_wrap", 32'(b_fc), 32'd255);
        applyStimulus(1'b1, "small_last");
        checkOutput("small_fc_wrapped", 32'(b_fc), 32'd0);
        checkOutput("small_fs_count", 32'(fs_count_b), 32'd256);

        @(negedge clk);
        line_end = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
